// File: rtl/clock_ctrl_pkg.sv
// Shared types and width helpers for the clock mode/sequencing controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_e;

  localparam int TIMEOUT_W = 32;

  // Counter width able to hold any value 0..v-1 with one spare bit.
  function automatic int cnt_w(input int unsigned v);
    return $clog2(v) + 1;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Pushbutton front end: 2-FF synchronizer, then a registered rising-edge pulse
// that appears three cycles after the first clock edge sampling the raw input high.
module btn_pulse (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic sync_lvl
);

  // [0],[1] synchronizer; [2],[3] delayed copies feeding the edge detector.
  logic [3:0] sh_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_reg <= '0;
      pulse  <= 1'b0;
    end else begin
      sh_reg <= {sh_reg[2:0], raw};
      pulse  <= sh_reg[2] & ~sh_reg[3];
    end
  end

  assign sync_lvl = sh_reg[1];

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode FSM, 1 Hz prescaler, auto-repeat, idle timeout and blink phase for the
// hours-minutes-seconds clock; all outputs are registered.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned HOLD_CYC    = 50000000,
  parameter int unsigned REPEAT_CYC  = 20000000,
  parameter int unsigned BLINK_CYC   = 25000000,
  parameter int unsigned TIMEOUT_CYC = 32'd1000000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic       tick_en,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int PW = cnt_w(TICK_DIV);
  localparam int HW = cnt_w(max2(HOLD_CYC, REPEAT_CYC));
  localparam int BW = cnt_w(BLINK_CYC);

  logic mode_pulse, up_pulse, up_lvl, mode_lvl_unused;

  btn_pulse u_mode_btn (
    .clk      (clk),
    .rst      (rst),
    .raw      (btn_mode),
    .pulse    (mode_pulse),
    .sync_lvl (mode_lvl_unused)
  );

  btn_pulse u_up_btn (
    .clk      (clk),
    .rst      (rst),
    .raw      (btn_up),
    .pulse    (up_pulse),
    .sync_lvl (up_lvl)
  );

  mode_e                mode_reg, mode_next;
  logic [PW-1:0]        presc_reg;
  logic [HW-1:0]        hold_cnt_reg;
  logic                 holding_reg, repeating_reg;
  logic [BW-1:0]        blink_cnt_reg;
  logic [TIMEOUT_W-1:0] idle_cnt_reg;
  logic in_set, next_in_set, up_act, rep_fire, strobe, timeout, mode_chg;

  always_comb begin
    in_set   = (mode_reg == SET_HOUR) || (mode_reg == SET_MIN);
    up_act   = in_set && up_pulse && !mode_pulse;
    // First repeat after HOLD_CYC, then every REPEAT_CYC; a mode or up pulse pre-empts it.
    rep_fire = in_set && holding_reg && up_lvl && !mode_pulse && !up_pulse &&
               (repeating_reg ? (hold_cnt_reg == HW'(REPEAT_CYC - 1))
                              : (hold_cnt_reg == HW'(HOLD_CYC - 1)));
    strobe   = up_act || rep_fire;
    timeout  = in_set && !mode_pulse && !strobe && (idle_cnt_reg == TIMEOUT_CYC - 1);

    mode_next = mode_reg;
    case (mode_reg)
      SET_HOUR: begin
        if (mode_pulse)   mode_next = SET_MIN;
        else if (timeout) mode_next = RUN;
      end
      SET_MIN: begin
        if (mode_pulse || timeout) mode_next = RUN;
      end
      RUN:     mode_next = mode_pulse ? SET_HOUR : RUN;
      default: mode_next = mode_pulse ? SET_HOUR : RUN;
    endcase
    next_in_set = (mode_next != RUN);
    mode_chg    = (mode_next != mode_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg      <= RUN;
      presc_reg     <= '0;
      hold_cnt_reg  <= '0;
      holding_reg   <= 1'b0;
      repeating_reg <= 1'b0;
      blink_cnt_reg <= '0;
      idle_cnt_reg  <= '0;
      tick_en       <= 1'b0;
      inc_hour      <= 1'b0;
      inc_min       <= 1'b0;
      sec_clr       <= 1'b0;
      blink         <= 1'b0;
    end else begin
      mode_reg <= mode_next;

      tick_en <= 1'b0;
      if (in_set) begin
        presc_reg <= '0;
      end else if (presc_reg == PW'(TICK_DIV - 1)) begin
        presc_reg <= '0;
        tick_en   <= 1'b1;
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end

      inc_hour <= strobe && (mode_reg == SET_HOUR);
      inc_min  <= strobe && (mode_reg == SET_MIN);
      sec_clr  <= in_set && !next_in_set;

      if (!in_set || mode_pulse || timeout) begin
        holding_reg <= 1'b0;
      end else if (up_pulse) begin
        holding_reg   <= 1'b1;
        repeating_reg <= 1'b0;
        hold_cnt_reg  <= '0;
      end else if (holding_reg) begin
        if (!up_lvl) begin
          holding_reg <= 1'b0;
        end else if (rep_fire) begin
          repeating_reg <= 1'b1;
          hold_cnt_reg  <= '0;
        end else begin
          hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end
      end

      if (!in_set || mode_chg || mode_pulse || up_pulse || strobe)
        idle_cnt_reg <= '0;
      else
        idle_cnt_reg <= idle_cnt_reg + 1'b1;

      // Blink restarts in the lit phase on mode entry and on every strobe.
      if (!next_in_set) begin
        blink         <= 1'b0;
        blink_cnt_reg <= '0;
      end else if (mode_chg || strobe) begin
        blink         <= 1'b1;
        blink_cnt_reg <= '0;
      end else if (blink_cnt_reg == BW'(BLINK_CYC - 1)) begin
        blink         <= ~blink;
        blink_cnt_reg <= '0;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  assign mode = mode_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized bench for clock_set_ctrl against a timestamp-based reference model
// built from the button, tick, repeat, timeout and blink rules.
module tb_clock_set_ctrl;

  localparam int TD   = 10;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int BC   = 4;
  localparam int TO   = 100;
  localparam int MAXC = 8000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       tick_en, inc_hour, inc_min, sec_clr, blink;
  logic [1:0] mode;

  clock_set_ctrl #(
    .TICK_DIV    (TD),
    .HOLD_CYC    (HOLD),
    .REPEAT_CYC  (REP),
    .BLINK_CYC   (BC),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .tick_en  (tick_en),
    .inc_hour (inc_hour),
    .inc_min  (inc_min),
    .sec_clr  (sec_clr),
    .mode     (mode),
    .blink    (blink)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int k        = 0;

  bit in_m [0:MAXC-1];
  bit in_u [0:MAXC-1];

  // Reference model state: times (cycle numbers) of the events that govern each output.
  int last_rst = 0, run_start = 0, blink_start = 0, idle_start = 0, up_press = -1;
  int m_mode = 0;
  bit e_tick = 0, e_ih = 0, e_im = 0, e_sc = 0, e_blink = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, k, got, exp);
  endtask

  function automatic bit rawm(input int j);
    if (j < last_rst) return 1'b0;
    return in_m[j];
  endfunction

  function automatic bit rawu(input int j);
    if (j < last_rst) return 1'b0;
    return in_u[j];
  endfunction

  // One clock: check outputs after edge k, predict edge k+1, drive inputs for it.
  task automatic cyc(input bit r, input bit bm, input bit bu);
    bit pm, pu, lv, rep;
    @(negedge clk);
    check_eq("tick_en",  int'(tick_en),  int'(e_tick));
    check_eq("inc_hour", int'(inc_hour), int'(e_ih));
    check_eq("inc_min",  int'(inc_min),  int'(e_im));
    check_eq("sec_clr",  int'(sec_clr),  int'(e_sc));
    check_eq("mode",     int'(mode),     m_mode);
    check_eq("blink",    int'(blink),    int'(e_blink));

    // A press is seen 3 cycles after the first edge sampling the raw level high.
    pm = rawm(k - 4) && !rawm(k - 5);
    pu = rawu(k - 4) && !rawu(k - 5);
    lv = rawu(k - 2);
    in_m[k] = bm;
    in_u[k] = bu;

    e_tick = 0; e_ih = 0; e_im = 0; e_sc = 0; rep = 0;
    if (r) begin
      last_rst = k + 1; run_start = k + 1; m_mode = 0; up_press = -1;
    end else if (m_mode == 0) begin
      e_tick   = ((k + 1 - run_start) % TD) == 0;
      up_press = -1;
      if (pm) begin m_mode = 1; blink_start = k + 1; idle_start = k + 1; end
    end else begin
      if (up_press >= 0 && k > up_press) begin
        if (!lv) up_press = -1;
        else if (k - up_press >= HOLD && ((k - up_press - HOLD) % REP) == 0) rep = 1;
      end
      if (pm) begin
        up_press = -1;
        if (m_mode == 1) begin m_mode = 2; blink_start = k + 1; idle_start = k + 1; end
        else begin m_mode = 0; e_sc = 1; run_start = k + 1; end
      end else if (pu || rep) begin
        if (m_mode == 1) e_ih = 1; else e_im = 1;
        if (pu) up_press = k;
        blink_start = k + 1; idle_start = k + 1;
      end else if (k - idle_start == TO - 1) begin
        m_mode = 0; e_sc = 1; run_start = k + 1; up_press = -1;
      end
    end
    e_blink = (m_mode != 0) && (((k + 1 - blink_start) / BC) % 2 == 0);

    rst = r; btn_mode = bm; btn_up = bu;
    k++;
  endtask

  task automatic run(input int n, input bit r, input bit bm, input bit bu);
    for (int i = 0; i < n; i++) cyc(r, bm, bu);
  endtask

  initial begin
    // Directed opening following the main use cases, then random segments.
    run(3, 1, 0, 0);  run(35, 0, 0, 0);
    $display("seg: reset + idle done at cycle %0d", k);
    run(3, 0, 1, 0);  run(20, 0, 0, 0);
    $display("seg: enter SET_HOUR at cycle %0d", k);
    run(2, 0, 0, 1);  run(8, 0, 0, 0);  run(2, 0, 0, 1);  run(8, 0, 0, 0);
    $display("seg: two up taps at cycle %0d", k);
    run(2, 0, 1, 0);  run(8, 0, 0, 0);
    run(40, 0, 0, 1); run(15, 0, 0, 0);
    $display("seg: hold up 40 in SET_MIN at cycle %0d", k);
    run(2, 0, 1, 1);  run(20, 0, 0, 0);
    $display("seg: mode+up together at cycle %0d", k);
    run(2, 0, 1, 0);  run(110, 0, 0, 0);
    $display("seg: timeout from SET_HOUR at cycle %0d", k);
    run(2, 0, 0, 1);  run(10, 0, 0, 0);
    run(2, 0, 1, 0);  run(8, 0, 0, 0);  run(30, 0, 0, 1);
    run(1, 1, 0, 1);  run(5, 0, 0, 1);  run(10, 0, 0, 0);
    $display("seg: reset during repeat hold at cycle %0d", k);

    for (int s = 0; s < 70 && k < MAXC - 200; s++) begin
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1: begin run($urandom_range(1, 4), 0, 1, 0); run($urandom_range(4, 15), 0, 0, 0); end
        2, 3: begin run($urandom_range(1, 3), 0, 0, 1); run($urandom_range(4, 12), 0, 0, 0); end
        4:    begin run($urandom_range(25, 50), 0, 0, 1); run(6, 0, 0, 0); end
        5:    begin run(2, 0, 1, 1); run($urandom_range(4, 10), 0, 0, 0); end
        6:    run(110, 0, 0, 0);
        7:    run($urandom_range(0, 30), 0, 0, 0);
        8:    begin
                run($urandom_range(10, 30), 0, 0, 1);
                run($urandom_range(1, 2), 1, 0, 1);
                run(4, 0, 0, 1); run(6, 0, 0, 0);
              end
        default: begin run(2, 0, 1, 0); run(6, 0, 0, 0); run($urandom_range(30, 45), 0, 0, 1); run(6, 0, 0, 0); end
      endcase
      $display("seg %0d: kind %0d ends at cycle %0d mode %0d", s, sel, k, m_mode);
    end

    run(4, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
